// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The fetch FSM state encoding, instruction size and PC alignment mask live here.
package instr_fetch_pkg;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_VALID = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
  localparam int CNT_W       = 4;

  // Clears the byte-offset bits so redirect targets land on an instruction boundary.
  localparam logic [63:0] PC_ALIGN_MASK = ~64'(INSTR_BYTES - 1);

endpackage

// File: rtl/instr_fetch_sequencer_fetch_wait_timer.sv
// Loadable down-counter that paces the instruction memory read latency.
// Load has priority over counting; the counter parks at zero until reloaded.
module fetch_wait_timer
  import instr_fetch_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch controller: owns the PC, paces multi-cycle instruction memory reads and
// hands captured words to decode over valid/ready, with redirects from execute.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_WAIT  | read in flight at pc; capture imem_data when the timer hits 0
//   ST_VALID | instr/instr_pc presented to decode, held until accepted
module instr_fetch_sequencer
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter int                INSTR_W     = 32,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               CLK,
  input  logic               resetl,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [31:0]        fetch_count
);

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = PC_ALIGN_MASK[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_BYTES);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic [31:0]        fetch_count_q;

  logic handshake;
  logic cnt_zero;

  assign handshake = (state_q == ST_VALID) && instr_ready;

  // A new read starts after every accepted word and after every redirect.
  fetch_wait_timer #(
    .RST_VAL (CNT_RELOAD)
  ) u_wait_timer (
    .clk_i      (CLK),
    .rst_ni     (resetl),
    .load_i     (redirect_valid || handshake),
    .load_val_i (CNT_RELOAD),
    .en_i       (state_q == ST_WAIT),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q       <= ST_WAIT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      // A handshake still counts when a redirect arrives in the same cycle.
      if (handshake && (fetch_count_q != '1)) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end

      if (redirect_valid) begin
        pc_q    <= redirect_pc & ALIGN_MASK;
        state_q <= ST_WAIT;
      end else begin
        case (state_q)
          ST_WAIT: begin
            if (cnt_zero) begin
              instr_q    <= imem_data;
              instr_pc_q <= pc_q;
              state_q    <= ST_VALID;
            end
          end
          ST_VALID: begin
            if (instr_ready) begin
              pc_q    <= pc_q + PC_STEP;
              state_q <= ST_WAIT;
            end
          end
          default: state_q <= ST_WAIT;
        endcase
      end
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd     = (state_q == ST_WAIT);
  assign instr_valid = (state_q == ST_VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: two instances (read latency 2 and 1) share stimulus
// and are compared every cycle against a timeline model of fetch issue and completion.
module tb_instr_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        instr_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  logic [63:0] imem_addr   [2];
  logic        imem_rd     [2];
  logic [31:0] imem_data   [2];
  logic [31:0] instr       [2];
  logic [63:0] instr_pc    [2];
  logic        instr_valid [2];
  logic [31:0] fetch_count [2];

  int n_vec = 0;
  int n_err = 0;

  // Model: each fetch is issued at cycle m_issue and becomes valid WAIT_CYCLES later.
  int          cyc;
  logic [63:0] m_pc    [2];
  int          m_issue [2];
  logic [31:0] m_instr [2];
  logic [63:0] m_ipc   [2];
  logic [31:0] m_cnt   [2];

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'hF840_03E9;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Memory drives X whenever no read is outstanding to expose stray captures.
  assign imem_data[0] = imem_rd[0] ? mem_word(imem_addr[0]) : 32'hxxxx_xxxx;
  assign imem_data[1] = imem_rd[1] ? mem_word(imem_addr[1]) : 32'hxxxx_xxxx;

  instr_fetch_sequencer #(
    .ADDR_W(64), .INSTR_W(32), .WAIT_CYCLES(2), .RESET_PC(64'h0)
  ) dut0 (
    .CLK(CLK), .resetl(resetl),
    .imem_addr(imem_addr[0]), .imem_rd(imem_rd[0]), .imem_data(imem_data[0]),
    .instr(instr[0]), .instr_pc(instr_pc[0]), .instr_valid(instr_valid[0]),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_count(fetch_count[0])
  );

  instr_fetch_sequencer #(
    .ADDR_W(64), .INSTR_W(32), .WAIT_CYCLES(1), .RESET_PC(64'h0)
  ) dut1 (
    .CLK(CLK), .resetl(resetl),
    .imem_addr(imem_addr[1]), .imem_rd(imem_rd[1]), .imem_data(imem_data[1]),
    .instr(instr[1]), .instr_pc(instr_pc[1]), .instr_valid(instr_valid[1]),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_count(fetch_count[1])
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]    = 64'h0;
      m_issue[k] = 0;
      m_instr[k] = 32'h0;
      m_ipc[k]   = 64'h0;
      m_cnt[k]   = 32'h0;
    end
    cyc = 0;
  endtask

  // Advance one clock: update the model with the current inputs, then compare both DUTs.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      bit v;
      bit hs;
      v  = (cyc >= m_issue[k] + wc(k));
      hs = v && instr_ready;
      if (hs && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
      if (redirect_valid) begin
        m_pc[k]    = redirect_pc & ~64'h3;
        m_issue[k] = cyc + 1;
      end else if (hs) begin
        m_pc[k]    = m_pc[k] + 64'd4;
        m_issue[k] = cyc + 1;
      end
    end
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (cyc == m_issue[k] + wc(k)) begin
        m_instr[k] = mem_word(m_pc[k]);
        m_ipc[k]   = m_pc[k];
      end
    end
    @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      bit v;
      v = (cyc >= m_issue[k] + wc(k));
      n_vec++;
      if (imem_addr[k] !== m_pc[k]) begin
        n_err++;
        $display("FAIL imem_addr dut%0d cyc %0d: got %h want %h", k, cyc, imem_addr[k], m_pc[k]);
      end
      n_vec++;
      if (imem_rd[k] !== !v) begin
        n_err++;
        $display("FAIL imem_rd dut%0d cyc %0d: got %b want %b", k, cyc, imem_rd[k], !v);
      end
      n_vec++;
      if (instr_valid[k] !== v) begin
        n_err++;
        $display("FAIL instr_valid dut%0d cyc %0d: got %b want %b", k, cyc, instr_valid[k], v);
      end
      n_vec++;
      if (instr[k] !== m_instr[k]) begin
        n_err++;
        $display("FAIL instr dut%0d cyc %0d: got %h want %h", k, cyc, instr[k], m_instr[k]);
      end
      n_vec++;
      if (instr_pc[k] !== m_ipc[k]) begin
        n_err++;
        $display("FAIL instr_pc dut%0d cyc %0d: got %h want %h", k, cyc, instr_pc[k], m_ipc[k]);
      end
      n_vec++;
      if (fetch_count[k] !== m_cnt[k]) begin
        n_err++;
        $display("FAIL fetch_count dut%0d cyc %0d: got %0d want %0d", k, cyc, fetch_count[k], m_cnt[k]);
      end
    end
  endtask

  task automatic wait_valid0(input string tag);
    int n;
    n = 0;
    while (!(cyc >= m_issue[0] + 2) && n < 20) begin
      step();
      n++;
    end
    n_vec++;
    if (instr_valid[0] !== 1'b1) begin
      n_err++;
      $display("FAIL %s wait_valid: instr_valid %b want 1 after %0d cycles", tag, instr_valid[0], n);
    end
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #3;
    resetl = 1'b1;
    cyc    = 0;
  endtask

  task automatic test_reset();
    resetl         = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (imem_rd[k] !== 1'b1 || instr_valid[k] !== 1'b0 || imem_addr[k] !== 64'h0 ||
          instr[k] !== 32'h0 || instr_pc[k] !== 64'h0 || fetch_count[k] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: rd=%b valid=%b addr=%h instr=%h ipc=%h cnt=%0d want rd=1 rest 0",
                 k, imem_rd[k], instr_valid[k], imem_addr[k], instr[k], instr_pc[k], fetch_count[k]);
      end
    end
    release_reset();
  endtask

  task automatic test_first_fetch();
    instr_ready = 1'b1;
    n_vec++;
    if (imem_rd[0] !== 1'b1) begin
      n_err++;
      $display("FAIL first_rd_c0: got %b want 1", imem_rd[0]);
    end
    step();
    n_vec++;
    if (imem_rd[0] !== 1'b1 || instr_valid[1] !== 1'b1) begin
      n_err++;
      $display("FAIL first_c1: rd0=%b valid1=%b want 1 1", imem_rd[0], instr_valid[1]);
    end
    step();
    n_vec++;
    if (instr_valid[0] !== 1'b1 || instr[0] !== 32'hF840_03E9 || instr_pc[0] !== 64'h0) begin
      n_err++;
      $display("FAIL first_c2: valid=%b instr=%h ipc=%h want 1 f84003e9 0",
               instr_valid[0], instr[0], instr_pc[0]);
    end
    step();
    n_vec++;
    if (imem_addr[0] !== 64'h4 || instr_valid[1] !== 1'b1) begin
      n_err++;
      $display("FAIL first_c3: addr0=%h valid1=%b want 4 1", imem_addr[0], instr_valid[1]);
    end
    step();
    n_vec++;
    if (instr_valid[1] !== 1'b0) begin
      n_err++;
      $display("FAIL wc1_c4: valid1=%b want 0", instr_valid[1]);
    end
    step();
    n_vec++;
    if (instr_valid[0] !== 1'b1 || instr_pc[0] !== 64'h4 || instr_valid[1] !== 1'b1) begin
      n_err++;
      $display("FAIL first_c5: valid0=%b ipc0=%h valid1=%b want 1 4 1",
               instr_valid[0], instr_pc[0], instr_valid[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] hold_pc;
    logic [31:0] hold_cnt;
    logic [31:0] hold_instr;
    instr_ready = 1'b0;
    wait_valid0("backpressure");
    hold_pc    = m_pc[0];
    hold_cnt   = m_cnt[0];
    hold_instr = mem_word(m_pc[0]);
    repeat (5) begin
      step();
      n_vec++;
      if (imem_addr[0] !== hold_pc || fetch_count[0] !== hold_cnt || imem_rd[0] !== 1'b0 ||
          instr[0] !== hold_instr || instr_pc[0] !== hold_pc) begin
        n_err++;
        $display("FAIL backpressure_hold: addr=%h cnt=%0d rd=%b instr=%h ipc=%h want %h %0d 0 %h %h",
                 imem_addr[0], fetch_count[0], imem_rd[0], instr[0], instr_pc[0],
                 hold_pc, hold_cnt, hold_instr, hold_pc);
      end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_vec++;
    if (fetch_count[0] !== hold_cnt + 32'd1 || imem_addr[0] !== hold_pc + 64'd4) begin
      n_err++;
      $display("FAIL backpressure_release: cnt=%0d addr=%h want %0d %h",
               fetch_count[0], imem_addr[0], hold_cnt + 32'd1, hold_pc + 64'd4);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    instr_ready = 1'b0;
    n = 0;
    while (cyc != m_issue[0] + 1 && n < 20) begin
      if (cyc >= m_issue[0] + 2) instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      n++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1E;
    step();
    redirect_valid = 1'b0;
    n_vec++;
    if (imem_addr[0] !== 64'h1C || instr_valid[0] !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_wait_addr: addr=%h valid=%b want 1c 0", imem_addr[0], instr_valid[0]);
    end
    step();
    n_vec++;
    if (instr_valid[0] !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_wait_early: valid=%b want 0", instr_valid[0]);
    end
    step();
    n_vec++;
    if (instr_valid[0] !== 1'b1 || instr_pc[0] !== 64'h1C || instr[0] !== mem_word(64'h1C)) begin
      n_err++;
      $display("FAIL redirect_wait_capture: valid=%b ipc=%h instr=%h want 1 1c %h",
               instr_valid[0], instr_pc[0], instr[0], mem_word(64'h1C));
    end
  endtask

  task automatic test_redirect_handshake();
    logic [63:0] start_pc [2];
    logic [31:0] cnt0;
    start_pc[0] = 64'h24;
    start_pc[1] = 64'h10;
    for (int i = 0; i < 2; i++) begin
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = start_pc[i];
      step();
      redirect_valid = 1'b0;
      wait_valid0("redirect_hs");
      cnt0           = m_cnt[0];
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h28;
      step();
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      n_vec++;
      if (fetch_count[0] !== cnt0 + 32'd1 || imem_addr[0] !== 64'h28) begin
        n_err++;
        $display("FAIL redirect_handshake from %h: cnt=%0d addr=%h want %0d 28",
                 start_pc[i], fetch_count[0], imem_addr[0], cnt0 + 32'd1);
      end
    end
  endtask

  task automatic test_wrap();
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    n_vec++;
    if (imem_addr[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_align: addr=%h want fffffffffffffffc", imem_addr[0]);
    end
    wait_valid0("wrap");
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_vec++;
    if (imem_addr[0] !== 64'h0 || imem_addr[1] !== 64'h0) begin
      n_err++;
      $display("FAIL wrap_addr: addr0=%h addr1=%h want 0 0", imem_addr[0], imem_addr[1]);
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    resetl = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (imem_rd[k] !== 1'b1 || instr_valid[k] !== 1'b0 || imem_addr[k] !== 64'h0 ||
          instr[k] !== 32'h0 || instr_pc[k] !== 64'h0 || fetch_count[k] !== 32'h0) begin
        n_err++;
        $display("FAIL %s dut%0d: rd=%b valid=%b addr=%h instr=%h ipc=%h cnt=%0d want rd=1 rest 0",
                 tag, k, imem_rd[k], instr_valid[k], imem_addr[k], instr[k], instr_pc[k], fetch_count[k]);
      end
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    @(posedge CLK);
    release_reset();
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    instr_ready    = 1'b0;
    step();
    redirect_valid = 1'b0;
    async_reset_check("async_reset_wait");
    instr_ready = 1'b1;
    repeat (4) step();
    instr_ready = 1'b0;
    wait_valid0("async_valid");
    async_reset_check("async_reset_valid");
    wait_valid0("restart");
    n_vec++;
    if (instr_pc[0] !== 64'h0 || instr[0] !== 32'hF840_03E9) begin
      n_err++;
      $display("FAIL restart_pc: ipc=%h instr=%h want 0 f84003e9", instr_pc[0], instr[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        redirect_pc = {32'($urandom), 32'($urandom)};
      step();
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_handshake();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
Fetch controller that owns the program counter and sequences reads from the multi-cycle instruction memory.
- Drives the memory address, waits a parameterised read latency, then captures the returned word.
- Presents the word to the decode stage with a valid/ready handshake.
- Accepts branch redirects from execute.
- Sits between the PC/next-PC logic and the instruction memory in the multi-cycle processor variant.

Parameters:
ADDR_W, 64, width of PC and memory address
INSTR_W, 32, instruction word width
WAIT_CYCLES, 2, memory read latency in cycles; legal range 1..15
RESET_PC, 64'h0, PC value loaded by reset

Ports:
CLK  in  1  clock; all state updates on rising edge
resetl  in  1  asynchronous reset, active-low
imem_addr  out  ADDR_W  address to instruction memory; always equals pc
imem_rd  out  1  high while a read is in flight (state WAIT)
imem_data  in  INSTR_W  read data from instruction memory
instr  out  INSTR_W  captured instruction word
instr_pc  out  ADDR_W  address the instr word was fetched from
instr_valid  out  1  instr/instr_pc hold a valid fetched instruction
instr_ready  in  1  decode accepts the instruction this cycle
redirect_valid  in  1  branch/jump redirect request
redirect_pc  in  ADDR_W  redirect target
fetch_count  out  32  number of completed handshakes; saturates at 32'hFFFFFFFF

Behaviour:
- Registers: pc, cnt[3:0], state, instr, instr_pc, fetch_count.
- States: WAIT and VALID.
- Reset (resetl low, asynchronous):
  - pc=RESET_PC, state=WAIT, cnt=WAIT_CYCLES-1.
  - instr=0, instr_pc=0, instr_valid=0, fetch_count=0.
  - imem_rd=1 immediately after release.
- Outputs per state:
  - imem_addr=pc at all times.
  - imem_rd=1 only in WAIT.
  - instr_valid=1 only in VALID.
- WAIT:
  - cnt!=0: cnt decrements.
  - cnt==0: instr<=imem_data, instr_pc<=pc, state->VALID.
- VALID:
  - Outputs are stable until the handshake (instr_valid & instr_ready).
  - On handshake: pc<=pc+4 (modulo 2^ADDR_W, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0), cnt<=WAIT_CYCLES-1, state->WAIT, fetch_count increments.
  - No handshake: hold all state.
- Latency and throughput:
  - First instr_valid occurs WAIT_CYCLES cycles after reset release (cycle WAIT_CYCLES, counting the release cycle as 0).
  - With instr_ready held high, one instruction is delivered every WAIT_CYCLES+1 cycles.
- Redirect (redirect_valid=1, any state) has priority over all other transitions:
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - cnt<=WAIT_CYCLES-1, state->WAIT.
  - In WAIT, no capture occurs that edge, even if cnt==0.
  - In VALID without ready, the held instruction is discarded; fetch_count is unchanged.
- Simultaneous redirect and handshake in VALID:
  - The handshake completes and fetch_count increments.
  - The next pc is the aligned redirect_pc, not pc+4.
- Data path: imem_data is sampled only at the capture edge; its value in other cycles is don't-care, including X.
- fetch_count saturates and does not wrap.
- Reset asserted mid-operation: all state returns to reset values asynchronously, with no partial capture.

Decomposition:
- Package instr_fetch_pkg holds:
  - the state encoding (WAIT=1'b0, VALID=1'b1)
  - INSTR_BYTES=4
  - the alignment mask constant
- One natural sub-module: fetch_wait_timer.
  - Loadable down-counter with load, en and zero flag.
  - Instantiated once for cnt.
- Everything else is inline.

Test Plan:
1. Reset release with imem returning 32'hF84003E9 at address 0, instr_ready=1, WAIT_CYCLES=2 -> imem_rd high at cycles 0-1; instr_valid at cycle 2 with instr=F84003E9, instr_pc=0; imem_addr=4 at cycle 3; next valid at cycle 5 with instr_pc=4.
2. Backpressure: instr_ready=0 for 5 cycles while VALID -> instr, instr_pc and imem_addr stable, imem_rd=0, fetch_count unchanged; ready=1 -> single increment, pc advances by 4.
3. Redirect during WAIT with cnt==0, redirect_pc=0x1E -> no capture; imem_addr=0x1C next cycle; valid 2 cycles later with instr_pc=0x1C, fetched word 32'h[national-id].
4. Simultaneous redirect(0x28) and handshake in VALID at pc=0x24 -> fetch_count+1; next imem_addr=0x28, not 0x28 via pc+4 ambiguity (check with pc=0x10: next addr 0x28, not 0x14).
5. Wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC, complete handshake -> imem_addr=0.
6. resetl pulsed low mid-WAIT and mid-VALID -> outputs reach reset values without a clock edge; fetching restarts at RESET_PC; also run with WAIT_CYCLES=1 (valid every 2 cycles).
